// File: rtl/servo_ramp_scheduler.sv
// ============================================================================
// Module   : servo_ramp_scheduler
// Brief    : Holds per-channel servo on-time setpoints. Accepts clamped target
//            commands and, once per PWM frame, walks every channel one bounded
//            step toward its target (round-robin, one channel per cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_ramp_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int ON_W         = 28,
    parameter int FRAME_CYCLES = 2000000,
    parameter int STEP         = 1000,
    parameter int MIN_ON       = 100000,
    parameter int MAX_ON       = 200000,
    parameter int INIT_ON      = 150000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CH_W-1:0]        cmd_ch,
    input  logic [ON_W-1:0]        cmd_target,
    input  logic                   freeze,
    output logic [NUM_CH*ON_W-1:0] ontime_out,
    output logic [NUM_CH-1:0]      load_strobe,
    output logic [NUM_CH-1:0]      busy,
    output logic                   frame_tick,
    output logic                   all_settled
);

    localparam int              CNT_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CH_W-1:0]  C_LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    C_NUM_CH   = (CH_W+1)'(NUM_CH);
    localparam logic [ON_W:0]    C_STEP     = (ON_W+1)'(STEP);
    localparam logic [ON_W-1:0]  C_MIN_ON   = ON_W'(MIN_ON);
    localparam logic [ON_W-1:0]  C_MAX_ON   = ON_W'(MAX_ON);
    localparam logic [ON_W-1:0]  C_INIT_ON  = ON_W'(INIT_ON);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0]  r_idx;
    logic [NUM_CH-1:0] r_strobe;
    logic [ON_W-1:0]  r_cur [NUM_CH];
    logic [ON_W-1:0]  r_tgt [NUM_CH];

    logic             w_frame_tick;
    logic             w_cmd_ch_ok;
    logic [ON_W-1:0]  w_clamped;
    logic [ON_W:0]    w_sel_cur;
    logic [ON_W:0]    w_sel_tgt;
    logic [ON_W:0]    w_up;
    logic [ON_W:0]    w_dn_lim;
    logic [ON_W-1:0]  w_next;

    assign w_frame_tick = (r_cnt == C_LAST_CNT);
    assign w_cmd_ch_ok  = ({1'b0, cmd_ch} < C_NUM_CH);

    // Widen by one bit so cur+STEP and tgt+STEP can never wrap
    assign w_sel_cur = {1'b0, r_cur[r_idx]};
    assign w_sel_tgt = {1'b0, r_tgt[r_idx]};
    assign w_up      = w_sel_cur + C_STEP;
    assign w_dn_lim  = w_sel_tgt + C_STEP;

    // Clamp incoming command into the legal servo window
    always_comb begin
        w_clamped = cmd_target;
        if (cmd_target < C_MIN_ON) begin
            w_clamped = C_MIN_ON;
        end else if (cmd_target > C_MAX_ON) begin
            w_clamped = C_MAX_ON;
        end
    end

    // Bounded step of the selected channel toward its target
    always_comb begin
        w_next = r_cur[r_idx];
        if (w_sel_cur < w_sel_tgt) begin
            w_next = (w_up < w_sel_tgt) ? w_up[ON_W-1:0] : r_tgt[r_idx];
        end else if (w_sel_cur > w_sel_tgt) begin
            // cur >= tgt+STEP guarantees cur-STEP does not underflow
            w_next = (w_sel_cur >= w_dn_lim) ? (r_cur[r_idx] - C_STEP[ON_W-1:0])
                                             : r_tgt[r_idx];
        end
    end

    // Frame counter, command capture and round-robin update sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_strobe <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cur[k] <= C_INIT_ON;
                r_tgt[k] <= C_INIT_ON;
            end
        end else begin
            r_cnt    <= w_frame_tick ? '0 : r_cnt + CNT_W'(1);
            r_strobe <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_frame_tick && !freeze) begin
                        r_state <= S_UPDATE;
                        r_idx   <= '0;
                    end else if (cmd_valid && !w_frame_tick && w_cmd_ch_ok) begin
                        // Out-of-range channels are accepted but dropped
                        r_tgt[cmd_ch] <= w_clamped;
                    end
                end
                S_UPDATE: begin
                    r_cur[r_idx] <= w_next;
                    if (w_next != r_cur[r_idx]) begin
                        r_strobe[r_idx] <= 1'b1;
                    end
                    r_idx <= r_idx + CH_W'(1);
                    if (r_idx == C_LAST_CH) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign ontime_out[k*ON_W +: ON_W] = r_cur[k];
            assign busy[k]                    = (r_cur[k] != r_tgt[k]);
        end
    endgenerate

    assign load_strobe = r_strobe;
    assign frame_tick  = w_frame_tick;
    assign cmd_ready   = (r_state == S_IDLE) && !w_frame_tick;
    assign all_settled = (busy == '0) && (r_state == S_IDLE);

endmodule

`default_nettype wire
